// File: rtl/ajc_cnvz_status_cond_unit_v_pkg.sv
// Shared flag layout and branch condition codes for the status/condition unit and sequencer.
package ajc_cnvz_status_cond_unit_v_pkg;

    // Bit positions of the CNVZ flags inside SR and Flags_In
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Branch condition codes (Cond_Sel)
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Masked flag update: bits with mask set take the new value, others keep the old one
    function automatic logic [3:0] masked_write(input logic [3:0] old_sr,
                                                input logic [3:0] new_flags,
                                                input logic [3:0] mask);
        return (new_flags & mask) | (old_sr & ~mask);
    endfunction

endpackage

// File: rtl/ajc_cnvz_cond_eval_v.sv
// Combinational branch condition evaluator: (SR, Cond_Sel) -> taken.
module ajc_cnvz_cond_eval_v
    import ajc_cnvz_status_cond_unit_v_pkg::*;
(
    input  logic [3:0] sr_i,
    input  logic [3:0] cond_sel_i,
    output logic       taken_o
);

    logic c, n, v, z;

    assign c = sr_i[FLAG_C];
    assign n = sr_i[FLAG_N];
    assign v = sr_i[FLAG_V];
    assign z = sr_i[FLAG_Z];

    // Decode the condition code into a single taken bit
    always_comb begin
        taken_o = 1'b0;
        case (cond_sel_i)
            COND_EQ: taken_o = z;
            COND_NE: taken_o = ~z;
            COND_CS: taken_o = c;
            COND_CC: taken_o = ~c;
            COND_MI: taken_o = n;
            COND_PL: taken_o = ~n;
            COND_VS: taken_o = v;
            COND_VC: taken_o = ~v;
            COND_HI: taken_o = c & ~z;
            COND_LS: taken_o = ~c | z;
            COND_GE: taken_o = ~(n ^ v);
            COND_LT: taken_o = n ^ v;
            COND_GT: taken_o = ~z & ~(n ^ v);
            COND_LE: taken_o = z | (n ^ v);
            COND_AL: taken_o = 1'b1;
            COND_NV: taken_o = 1'b0;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ajc_cnvz_status_cond_unit_v.sv
// Status register with masked CNVZ capture, flag save/restore stack and registered
// branch condition evaluation (forwarded from the next SR value).
module ajc_cnvz_status_cond_unit_v
    import ajc_cnvz_status_cond_unit_v_pkg::*;
#(
    parameter int STACK_DEPTH = 2,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [3:0]    Flags_In,
    input  logic [3:0]    Flag_Mask,
    input  logic          Flag_WE,
    input  logic          Flag_Save,
    input  logic          Flag_Restore,
    input  logic          Br_Req,
    input  logic [3:0]    Cond_Sel,
    output logic          Br_Valid,
    output logic          Br_Taken,
    output logic [3:0]    SR_Out,
    output logic [DW-1:0] Stack_Depth,
    output logic          Stack_Err
);

    localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);

    logic [3:0]    sr_q, sr_d;
    logic [3:0]    stack_q [STACK_DEPTH];
    logic [3:0]    stack_d [STACK_DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic          br_valid_q, br_taken_q, br_taken_d;

    logic          save_only, restore_only, conflict;
    logic          full, empty, push, pop;
    logic [3:0]    top_sr;
    logic          taken_next;

    assign save_only    = Flag_Save & ~Flag_Restore;
    assign restore_only = Flag_Restore & ~Flag_Save;
    assign conflict     = Flag_Save & Flag_Restore;
    assign full         = (depth_q == FULL_DEPTH);
    assign empty        = (depth_q == '0);
    assign push         = save_only & ~full;
    assign pop          = restore_only & ~empty;

    // Select the occupied top-of-stack entry; only consumed when the stack is non-empty
    always_comb begin
        top_sr = 4'h0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (i == int'(depth_q) - 1) top_sr = stack_q[i];
        end
    end

    // Next-state: restore beats write beats hold; push captures the pre-write SR
    always_comb begin
        sr_d    = sr_q;
        depth_d = depth_q;
        err_d   = err_q | conflict | (save_only & full) | (restore_only & empty);
        for (int i = 0; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i];

        if (pop) begin
            sr_d    = top_sr;
            depth_d = depth_q - DW'(1);
        end else if (Flag_WE) begin
            sr_d = masked_write(sr_q, Flags_In, Flag_Mask);
        end

        if (push) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (i == int'(depth_q)) stack_d[i] = sr_q;
            end
            depth_d = depth_q + DW'(1);
        end
    end

    ajc_cnvz_cond_eval_v u_cond_eval (
        .sr_i       (sr_d),
        .cond_sel_i (Cond_Sel),
        .taken_o    (taken_next)
    );

    // Taken result is held between requests
    assign br_taken_d = Br_Req ? taken_next : br_taken_q;

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sr_q       <= 4'h0;
            depth_q    <= '0;
            err_q      <= 1'b0;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 4'h0;
        end else begin
            sr_q       <= sr_d;
            depth_q    <= depth_d;
            err_q      <= err_d;
            br_valid_q <= Br_Req;
            br_taken_q <= br_taken_d;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign SR_Out      = sr_q;
    assign Stack_Depth = depth_q;
    assign Stack_Err   = err_q;
    assign Br_Valid    = br_valid_q;
    assign Br_Taken    = br_taken_q;

endmodule

// File: tb/tb_ajc_cnvz_status_cond_unit_v.sv
// Self-checking bench for the CNVZ status/condition unit: directed steps, a full
// condition sweep and random traffic against a queue-based reference model.
module tb_ajc_cnvz_status_cond_unit_v;

    localparam int DEPTH = 2;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          Clock = 1'b0;
    logic          Reset;
    logic [3:0]    Flags_In, Flag_Mask, Cond_Sel;
    logic          Flag_WE, Flag_Save, Flag_Restore, Br_Req;
    logic          Br_Valid, Br_Taken, Stack_Err;
    logic [3:0]    SR_Out;
    logic [DW-1:0] Stack_Depth;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] m_sr;
    logic [3:0] m_stack[$];
    bit         m_err, m_valid, m_taken;

    ajc_cnvz_status_cond_unit_v #(.STACK_DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .Flags_In(Flags_In), .Flag_Mask(Flag_Mask),
        .Flag_WE(Flag_WE), .Flag_Save(Flag_Save), .Flag_Restore(Flag_Restore),
        .Br_Req(Br_Req), .Cond_Sel(Cond_Sel), .Br_Valid(Br_Valid), .Br_Taken(Br_Taken),
        .SR_Out(SR_Out), .Stack_Depth(Stack_Depth), .Stack_Err(Stack_Err)
    );

    always #5 Clock = ~Clock;

    // Conditions come in complementary pairs: odd codes invert the even one
    function automatic bit cond_ref(logic [3:0] sr, logic [3:0] code);
        bit c, n, v, z, p;
        c = sr[3]; n = sr[2]; v = sr[1]; z = sr[0];
        case (code[3:1])
            3'd0: p = z;
            3'd1: p = c;
            3'd2: p = n;
            3'd3: p = v;
            3'd4: p = c && !z;
            3'd5: p = (n == v);
            3'd6: p = !z && (n == v);
            default: p = 1'b1;
        endcase
        return code[0] ? !p : p;
    endfunction

    function automatic logic [3:0] wr_ref(logic [3:0] sr, logic [3:0] in, logic [3:0] mask);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = mask[i] ? in[i] : sr[i];
        return r;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_edge();
        logic [3:0] wr;
        wr = Flag_WE ? wr_ref(m_sr, Flags_In, Flag_Mask) : m_sr;
        if (Flag_Save && Flag_Restore) begin
            m_err = 1'b1;
            m_sr  = wr;
        end else if (Flag_Restore) begin
            if (m_stack.size() > 0) m_sr = m_stack.pop_back();
            else begin m_err = 1'b1; m_sr = wr; end
        end else begin
            if (Flag_Save) begin
                if (m_stack.size() < DEPTH) m_stack.push_back(m_sr);
                else m_err = 1'b1;
            end
            m_sr = wr;
        end
        m_valid = Br_Req;
        if (Br_Req) m_taken = cond_ref(m_sr, Cond_Sel);
    endtask

    task automatic model_reset();
        m_sr = 4'h0; m_stack.delete(); m_err = 0; m_valid = 0; m_taken = 0;
    endtask

    task automatic chk(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".sr"},    int'(SR_Out),      int'(m_sr));
        chk({tag, ".depth"}, int'(Stack_Depth), m_stack.size());
        chk({tag, ".err"},   int'(Stack_Err),   int'(m_err));
        chk({tag, ".valid"}, int'(Br_Valid),    int'(m_valid));
        chk({tag, ".taken"}, int'(Br_Taken),    int'(m_taken));
    endtask

    task automatic drive(bit we, logic [3:0] mask, logic [3:0] in, bit sv, bit rs,
                         bit req, logic [3:0] cs);
        Flag_WE = we; Flag_Mask = mask; Flags_In = in; Flag_Save = sv;
        Flag_Restore = rs; Br_Req = req; Cond_Sel = cs;
    endtask

    task automatic idle();
        drive(0, 4'h0, 4'h0, 0, 0, 0, 4'h0);
    endtask

    // One clock: update model at the edge, compare 1 time unit later
    task automatic cyc(string tag);
        @(posedge Clock);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset(string tag);
        @(negedge Clock);
        Reset = 1'b1;
        idle();
        #1;
        model_reset();
        chk_all(tag);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        model_reset();
        #2;
        chk_all("reset");
        chk("reset.sr_const", int'(SR_Out), 0);
        #10 Reset = 1'b0;

        // Full-mask write, then asynchronous reset mid-cycle with a branch result pending
        drive(1, 4'hF, 4'h5, 0, 0, 1, 4'hE);
        cyc("wr0101");
        chk("wr0101.const", int'(SR_Out), 4'h5);
        chk("wr0101.valid_const", int'(Br_Valid), 1);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk_all("midreset");
        chk("midreset.sr_const", int'(SR_Out), 0);
        Reset = 1'b0;
        idle();

        // Per-bit masking
        drive(1, 4'hF, 4'hF, 0, 0, 0, 4'h0); cyc("wr1111");
        drive(1, 4'h1, 4'h0, 0, 0, 0, 4'h0); cyc("mask0001");
        chk("mask0001.const", int'(SR_Out), 4'hE);
        drive(1, 4'h0, 4'h0, 0, 0, 0, 4'h0); cyc("mask0000");
        chk("mask0000.const", int'(SR_Out), 4'hE);

        // Branch sees the same-cycle write
        drive(1, 4'hF, 4'h1, 0, 0, 1, 4'h0); cyc("fwd_eq");
        chk("fwd_eq.const", int'(Br_Taken), 1);
        drive(1, 4'hF, 4'h4, 0, 0, 1, 4'hA); cyc("fwd_ge");
        chk("fwd_ge.const", int'(Br_Taken), 0);
        idle(); cyc("taken_hold");

        // Every condition against every SR value, back-to-back requests
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 16; c++) begin
                drive(1, 4'hF, 4'(s), 0, 0, 1, 4'(c));
                cyc("sweep");
            end
        end
        idle(); cyc("sweep_end");

        // Stack fill, overflow, drain, underflow
        do_reset("rst_stack");
        drive(1, 4'hF, 4'hA, 0, 0, 0, 4'h0); cyc("st_wr1010");
        drive(0, 4'h0, 4'h0, 1, 0, 0, 4'h0); cyc("st_save1");
        drive(1, 4'hF, 4'h3, 0, 0, 0, 4'h0); cyc("st_wr0011");
        drive(0, 4'h0, 4'h0, 1, 0, 0, 4'h0); cyc("st_save2");
        drive(0, 4'h0, 4'h0, 1, 0, 0, 4'h0); cyc("st_save3");
        chk("st_over.depth_const", int'(Stack_Depth), 2);
        chk("st_over.err_const", int'(Stack_Err), 1);
        drive(1, 4'hF, 4'h0, 0, 0, 0, 4'h0); cyc("st_clr");
        drive(0, 4'h0, 4'h0, 0, 1, 0, 4'h0); cyc("st_rest1");
        chk("st_rest1.const", int'(SR_Out), 4'h3);
        drive(0, 4'h0, 4'h0, 0, 1, 0, 4'h0); cyc("st_rest2");
        chk("st_rest2.const", int'(SR_Out), 4'hA);
        drive(0, 4'h0, 4'h0, 0, 1, 0, 4'h0); cyc("st_under");
        chk("st_under.const", int'(SR_Out), 4'hA);

        // Save+restore conflict, then restore racing a write
        do_reset("rst_conf");
        drive(1, 4'hF, 4'h6, 0, 0, 0, 4'h0); cyc("cf_wr");
        drive(0, 4'h0, 4'h0, 1, 0, 0, 4'h0); cyc("cf_save");
        drive(1, 4'hF, 4'h8, 1, 1, 0, 4'h0); cyc("cf_both");
        chk("cf_both.sr_const", int'(SR_Out), 4'h8);
        chk("cf_both.depth_const", int'(Stack_Depth), 1);
        chk("cf_both.err_const", int'(Stack_Err), 1);
        drive(1, 4'hF, 4'h1, 0, 1, 1, 4'h0); cyc("cf_rest_we");
        chk("cf_rest_we.const", int'(SR_Out), 4'h6);

        // Random traffic
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom));
            cyc("rand");
            if (i == 200) do_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
